// File: rtl/npu_bus_slave.sv
// ---------------------------------------------------------------------------------------------
// npu_bus_slave
//
// Pipelined address/data-phase bus slave that bridges the system bus onto one NPU memory port.
// Each accepted address phase is decoded into a write, a read or an error data phase:
//   - write : single data-phase cycle, NPU strobe with write enable, no wait states
//   - read  : NPU strobe in the first cycle, then RdLatency wait states until rdata_i is valid
//   - error : two cycles, resp_o high in both, ready_o low in the first; no NPU access
// A new address phase is only looked at in a cycle where ready_o is high.
//
// Parameters
//   DWidth     data bus width
//   AWidth     address width
//   RdLatency  NPU read latency in cycles (1..7)
//   BaseAddr   address window base
//   AddrMask   address window mask; hit when (addr & AddrMask) == BaseAddr
//
// Ports
//   clk_i     clock, rising edge
//   rst_ni    asynchronous active-low reset
//   sel_i     slave select from the bus decoder
//   trans_i   transfer type (IDLE=00, BUSY=01, NONSEQ=10, SEQ=11)
//   ready_i   bus-wide ready, previous data phase complete
//   write_i   1 = write, 0 = read (address phase)
//   addr_i    address (address phase)
//   wdata_i   write data (data phase)
//   rdata_i   NPU read data, valid RdLatency cycles after a read strobe
//   cen_o     NPU access strobe, one cycle per access
//   wen_o     NPU write enable, qualified by cen_o
//   addr_o    NPU address, registered at address-phase acceptance
//   wdata_o   NPU write data
//   rdata_o   read data to master (live on read completion, otherwise last read data)
//   resp_o    0 = OKAY, 1 = ERROR
//   ready_o   data phase complete
// ---------------------------------------------------------------------------------------------
module npu_bus_slave #(
    parameter int unsigned        DWidth    = 32,
    parameter int unsigned        AWidth    = 32,
    parameter int unsigned        RdLatency = 1,
    parameter logic [AWidth-1:0]  BaseAddr  = AWidth'(32'h1000_0000),
    parameter logic [AWidth-1:0]  AddrMask  = AWidth'(32'hF000_0000)
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              sel_i,
    input  logic [1:0]        trans_i,
    input  logic              ready_i,
    input  logic              write_i,
    input  logic [AWidth-1:0] addr_i,
    input  logic [DWidth-1:0] wdata_i,
    input  logic [DWidth-1:0] rdata_i,
    output logic              cen_o,
    output logic              wen_o,
    output logic [AWidth-1:0] addr_o,
    output logic [DWidth-1:0] wdata_o,
    output logic [DWidth-1:0] rdata_o,
    output logic              resp_o,
    output logic              ready_o
);

    // Latency counter compare value; the counter only needs to reach 7.
    localparam logic [2:0] LatCnt = 3'(RdLatency);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StRead,
        StErr1,
        StErr2
    } state_e;

    state_e            state_q, state_d;
    logic [2:0]        cnt_q, cnt_d;
    logic [AWidth-1:0] addr_q, addr_d;
    logic [DWidth-1:0] hold_q, hold_d;

    logic accept;
    logic hit;
    logic aligned;
    logic rd_done;
    logic phase_end;

    // ------------------------------------------------------------------
    // Address-phase decode
    // ------------------------------------------------------------------
    // NONSEQ (10) and SEQ (11) are the only transfer types carrying an access.
    assign accept  = sel_i & ready_i & trans_i[1];
    assign hit     = ((addr_i & AddrMask) == BaseAddr);
    assign aligned = (addr_i[1:0] == 2'b00);

    // Read completes in the cycle the counter reaches the configured latency.
    assign rd_done = (state_q == StRead) && (cnt_q == LatCnt);

    // The current data phase ends (ready_o high) everywhere except during read wait states
    // and the first error cycle. Only then is the next address phase evaluated.
    assign phase_end = ((state_q != StRead) && (state_q != StErr1)) || rd_done;

    // ------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= StIdle;
            cnt_q   <= 3'd0;
            addr_q  <= '0;
            hold_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            hold_q  <= hold_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (phase_end) begin
            if (!accept) begin
                state_d = StIdle;
            end else if (!(hit && aligned)) begin
                state_d = StErr1;
            end else if (write_i) begin
                state_d = StWrite;
            end else begin
                state_d = StRead;
            end
        end else if (state_q == StErr1) begin
            state_d = StErr2;
        end
    end

    // Datapath next values. The counter restarts at every phase boundary so a newly entered
    // read always begins at zero, including back-to-back reads.
    always_comb begin
        addr_d = addr_q;
        cnt_d  = cnt_q;
        hold_d = hold_q;

        if (phase_end && accept) begin
            addr_d = addr_i;
        end

        if (phase_end) begin
            cnt_d = 3'd0;
        end else if (state_q == StRead) begin
            cnt_d = cnt_q + 3'd1;
        end

        if (rd_done) begin
            hold_d = rdata_i;
        end
    end

    // ------------------------------------------------------------------
    // Output logic
    // ------------------------------------------------------------------
    always_comb begin
        cen_o   = 1'b0;
        wen_o   = 1'b0;
        resp_o  = 1'b0;
        ready_o = phase_end;
        addr_o  = addr_q;
        wdata_o = wdata_i;
        rdata_o = rd_done ? rdata_i : hold_q;

        unique case (state_q)
            StIdle: begin
            end
            StWrite: begin
                cen_o = 1'b1;
                wen_o = 1'b1;
            end
            StRead: begin
                // Strobe only in the first read cycle; later cycles are wait states.
                cen_o = (cnt_q == 3'd0);
            end
            StErr1, StErr2: begin
                resp_o = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule

// File: tb/tb_npu_bus_slave.sv
// ---------------------------------------------------------------------------------------------
// tb_npu_bus_slave
//
// Directed sequences followed by random bus traffic against npu_bus_slave. A transaction-level
// reference model (current data phase kind plus its cycle index, a reference memory and the
// last-read register) predicts every output each cycle. A separate NPU memory model answers
// read strobes RdLatency cycles later and drives random garbage on rdata_i otherwise.
// ---------------------------------------------------------------------------------------------
module tb_npu_bus_slave;

    localparam int unsigned LAT  = 3;
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] MASK = 32'hF000_0000;

    localparam logic [1:0] T_IDLE   = 2'b00;
    localparam logic [1:0] T_BUSY   = 2'b01;
    localparam logic [1:0] T_NONSEQ = 2'b10;
    localparam logic [1:0] T_SEQ    = 2'b11;

    logic        clk_i;
    logic        rst_ni;
    logic        sel_i;
    logic [1:0]  trans_i;
    logic        ready_i;
    logic        write_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic [31:0] rdata_i;
    logic        cen_o;
    logic        wen_o;
    logic [31:0] addr_o;
    logic [31:0] wdata_o;
    logic [31:0] rdata_o;
    logic        resp_o;
    logic        ready_o;

    npu_bus_slave #(
        .DWidth    (32),
        .AWidth    (32),
        .RdLatency (LAT),
        .BaseAddr  (BASE),
        .AddrMask  (MASK)
    ) dut (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .sel_i   (sel_i),
        .trans_i (trans_i),
        .ready_i (ready_i),
        .write_i (write_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .rdata_i (rdata_i),
        .cen_o   (cen_o),
        .wen_o   (wen_o),
        .addr_o  (addr_o),
        .wdata_o (wdata_o),
        .rdata_o (rdata_o),
        .resp_o  (resp_o),
        .ready_o (ready_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;
    int cyc_n    = 0;
    int waits    = 0;   // DUT cycles seen with ready_o low
    int cens     = 0;   // DUT cycles seen with cen_o high

    // NPU memory model: pending read returns, due on a given cycle index
    typedef struct {
        int          due;
        logic [31:0] data;
    } rd_t;
    rd_t         pq[$];
    logic [31:0] npu_mem [logic [31:0]];

    // Reference model
    typedef enum int {MIdle, MWrite, MRead, MErr} mkind_e;
    mkind_e      m_kind;
    int          m_k;
    logic [31:0] m_addr;
    logic [31:0] m_hold;
    logic        m_rdy_last;
    logic [31:0] ref_mem [logic [31:0]];

    function automatic logic legal(input logic [31:0] a);
        return ((a & MASK) == BASE) && (a[1:0] == 2'b00);
    endfunction

    function automatic logic [31:0] rd_ref(input logic [31:0] a);
        return ref_mem.exists(a) ? ref_mem[a] : 32'h0;
    endfunction

    function automatic logic [31:0] rd_npu(input logic [31:0] a);
        return npu_mem.exists(a) ? npu_mem[a] : 32'h0;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_kind     = MIdle;
        m_k        = 0;
        m_addr     = 32'h0;
        m_hold     = 32'h0;
        m_rdy_last = 1'b1;
        pq.delete();
    endtask

    // One bus cycle: drive at negedge, check mid-cycle, advance models at posedge.
    task automatic step(input logic s, input logic [1:0] t, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] wd);
        logic        e_rdy, e_cen, e_wen, e_resp;
        logic [31:0] e_rdata;
        logic        o_cen, o_wen;
        logic [31:0] o_addr, o_wdata;

        @(negedge clk_i);
        sel_i   = s;
        trans_i = t;
        ready_i = r;
        write_i = w;
        addr_i  = a;
        wdata_i = wd;
        if (pq.size() > 0 && pq[0].due == cyc_n) rdata_i = pq[0].data;
        else                                     rdata_i = $urandom;
        #1;

        e_rdy   = (m_kind == MIdle) || (m_kind == MWrite) ||
                  (m_kind == MRead && m_k == LAT) || (m_kind == MErr && m_k == 1);
        e_cen   = (m_kind == MWrite) || (m_kind == MRead && m_k == 0);
        e_wen   = (m_kind == MWrite);
        e_resp  = (m_kind == MErr);
        e_rdata = (m_kind == MRead && m_k == LAT) ? rd_ref(m_addr) : m_hold;

        chk("ready", 32'(ready_o), 32'(e_rdy));
        chk("cen",   32'(cen_o),   32'(e_cen));
        chk("wen",   32'(wen_o),   32'(e_wen));
        chk("resp",  32'(resp_o),  32'(e_resp));
        chk("rdata", rdata_o, e_rdata);
        if (e_cen) chk("addr", addr_o, m_addr);
        if (e_wen) chk("wdata", wdata_o, wd);

        if (!ready_o) waits++;
        if (cen_o)    cens++;
        m_rdy_last = e_rdy;
        o_cen   = cen_o;
        o_wen   = wen_o;
        o_addr  = addr_o;
        o_wdata = wdata_o;

        @(posedge clk_i);
        // NPU side
        if (pq.size() > 0 && pq[0].due == cyc_n) void'(pq.pop_front());
        if (o_cen && o_wen)  npu_mem[o_addr] = o_wdata;
        if (o_cen && !o_wen) pq.push_back('{due: cyc_n + int'(LAT), data: rd_npu(o_addr)});
        cyc_n++;

        // Reference model
        if (m_kind == MWrite) ref_mem[m_addr] = wd;
        if (m_kind == MRead && m_k == LAT) m_hold = rd_ref(m_addr);
        if (e_rdy) begin
            if (s && r && (t == T_NONSEQ || t == T_SEQ)) begin
                m_addr = a;
                m_k    = 0;
                if (!legal(a)) m_kind = MErr;
                else if (w)    m_kind = MWrite;
                else           m_kind = MRead;
            end else begin
                m_kind = MIdle;
                m_k    = 0;
            end
        end else begin
            m_k++;
        end
    endtask

    // Master behaviour: hold the address phase until the cycle where the data phase completes.
    task automatic xfer(input logic s, input logic [1:0] t, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] wd);
        int n = 0;
        do begin
            step(s, t, r, w, a, wd);
            n++;
        end while (!m_rdy_last && n < 20);
        if (n >= 20) chk("xfer_bound", 32'(n), 32'd0);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 9))
            0:       return 32'h2000_0000;
            1:       return 32'h0000_0010;
            2:       return BASE + 32'(($urandom_range(0, 7) * 4) + $urandom_range(1, 3));
            3:       return 32'h1FFF_FFFC;
            default: return BASE + 32'($urandom_range(0, 7) * 4);
        endcase
    endfunction

    initial begin
        int w0;
        int c0;
        logic s, r, w;
        logic [1:0] t;

        rst_ni  = 1'b0;
        sel_i   = 1'b0;
        trans_i = T_IDLE;
        ready_i = 1'b1;
        write_i = 1'b0;
        addr_i  = 32'h0;
        wdata_i = 32'h0;
        rdata_i = 32'h0;
        model_reset();

        // Reset values
        repeat (2) @(posedge clk_i);
        #1;
        chk("rst_cen",   32'(cen_o),   32'd0);
        chk("rst_wen",   32'(wen_o),   32'd0);
        chk("rst_resp",  32'(resp_o),  32'd0);
        chk("rst_ready", 32'(ready_o), 32'd1);
        chk("rst_rdata", rdata_o,      32'h0);
        chk("rst_addr",  addr_o,       32'h0);
        @(negedge clk_i);
        rst_ni = 1'b1;

        // Single write
        xfer(1'b1, T_NONSEQ, 1'b1, 1'b1, 32'h1000_0010, 32'h0);
        xfer(1'b1, T_IDLE,   1'b1, 1'b0, 32'h0,         32'hDEAD_BEEF);

        // Single read with LAT wait states, then hold of the read data
        w0 = waits;
        xfer(1'b1, T_NONSEQ, 1'b1, 1'b0, 32'h1000_0010, 32'h0);
        xfer(1'b1, T_IDLE,   1'b1, 1'b0, 32'h0,         32'h0);
        chk("rd_waits", 32'(waits - w0), 32'(LAT));
        xfer(1'b1, T_IDLE,   1'b1, 1'b0, 32'h0,         32'h0);
        chk("rd_hold", rdata_o, 32'hDEAD_BEEF);

        // Out-of-window read and misaligned write: two-cycle error, no NPU access
        c0 = cens;
        w0 = waits;
        xfer(1'b1, T_NONSEQ, 1'b1, 1'b0, 32'h2000_0000, 32'h0);
        xfer(1'b1, T_NONSEQ, 1'b1, 1'b1, 32'h1000_0002, 32'h0);
        xfer(1'b1, T_IDLE,   1'b1, 1'b0, 32'h0,         32'h1234_5678);
        chk("err_no_cen", 32'(cens - c0), 32'd0);
        chk("err_waits",  32'(waits - w0), 32'd2);

        // Back-to-back write A, read A, write B
        w0 = waits;
        c0 = cens;
        xfer(1'b1, T_NONSEQ, 1'b1, 1'b1, 32'h1000_0100, 32'h0);
        xfer(1'b1, T_NONSEQ, 1'b1, 1'b0, 32'h1000_0100, 32'hA5A5_0001);
        xfer(1'b1, T_SEQ,    1'b1, 1'b1, 32'h1000_0104, 32'h0);
        xfer(1'b1, T_IDLE,   1'b1, 1'b0, 32'h0,         32'h5A5A_0002);
        chk("b2b_waits", 32'(waits - w0), 32'(LAT));
        chk("b2b_cens",  32'(cens - c0),  32'd3);
        chk("b2b_rdata", rdata_o, 32'hA5A5_0001);

        // Non-transfers: BUSY, IDLE, deselected NONSEQ, NONSEQ with ready_i low
        c0 = cens;
        step(1'b1, T_BUSY,   1'b1, 1'b1, 32'h1000_0020, 32'h0);
        step(1'b1, T_IDLE,   1'b1, 1'b1, 32'h1000_0020, 32'h0);
        step(1'b0, T_NONSEQ, 1'b1, 1'b1, 32'h1000_0020, 32'h0);
        step(1'b1, T_NONSEQ, 1'b0, 1'b0, 32'h1000_0020, 32'h0);
        step(1'b1, T_IDLE,   1'b1, 1'b0, 32'h0,         32'h0);
        chk("idle_no_cen", 32'(cens - c0), 32'd0);

        // Reset during the second cycle of a read
        xfer(1'b1, T_NONSEQ, 1'b1, 1'b0, 32'h1000_0100, 32'h0);
        step(1'b1, T_IDLE,   1'b1, 1'b0, 32'h0,         32'h0);
        #2;
        rst_ni = 1'b0;
        #1;
        chk("arst_cen",   32'(cen_o),   32'd0);
        chk("arst_resp",  32'(resp_o),  32'd0);
        chk("arst_ready", 32'(ready_o), 32'd1);
        chk("arst_rdata", rdata_o,      32'h0);
        chk("arst_addr",  addr_o,       32'h0);
        model_reset();
        sel_i   = 1'b0;
        trans_i = T_IDLE;
        @(posedge clk_i);
        #1;
        chk("arst_cen2", 32'(cen_o), 32'd0);
        @(negedge clk_i);
        rst_ni = 1'b1;
        xfer(1'b1, T_NONSEQ, 1'b1, 1'b0, 32'h1000_0104, 32'h0);
        xfer(1'b1, T_IDLE,   1'b1, 1'b0, 32'h0,         32'h0);
        chk("post_rst_rd", rdata_o, 32'h5A5A_0002);

        // Random traffic; inputs may change during wait states and must be ignored there
        for (int i = 0; i < 500; i++) begin
            s = ($urandom_range(0, 7) != 0);
            t = 2'($urandom_range(0, 3));
            r = ($urandom_range(0, 7) != 0);
            w = 1'($urandom_range(0, 1));
            step(s, t, r, w, rand_addr(), $urandom);
        end
        repeat (LAT + 2) step(1'b0, T_IDLE, 1'b1, 1'b0, 32'h0, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/npu_bus_slave.md
# npu_bus_slave

Parametrised bus-slave bridge between the system bus and the NPU memory port. It replaces the fixed single-cycle NPU interface with a pipelined address/data-phase slave. The slave has a configurable NPU read latency with wait-state insertion, a parametrised address window, and a two-cycle ERROR response for illegal accesses. It sits behind the bus decoder in the NPU top, one instance per NPU memory port.

## Interface
- DWidth, 32, data bus width
- AWidth, 32, address width
- RdLatency, 1, NPU read latency in cycles (legal 1..7); rdata_i is valid RdLatency cycles after the cen_o read strobe
- BaseAddr, 'h1000_0000, address window base
- AddrMask, 'hF000_0000, window mask; an address hits when (addr & AddrMask) == BaseAddr
- clk_i  input  1  clock, rising edge
- rst_ni  input  1  reset, asynchronous, active-low
- sel_i  input  1  slave select from decoder
- trans_i  input  2  transfer type: IDLE=00, BUSY=01, NONSEQ=10, SEQ=11
- ready_i  input  1  bus-wide ready (previous data phase complete)
- write_i  input  1  1 = write, 0 = read (address phase)
- addr_i  input  AWidth  address (address phase)
- wdata_i  input  DWidth  write data (data phase)
- rdata_i  input  DWidth  NPU read data
- cen_o  output  1  NPU access strobe, one cycle per access
- wen_o  output  1  NPU write enable, qualified by cen_o
- addr_o  output  AWidth  NPU address (registered)
- wdata_o  output  DWidth  NPU write data
- rdata_o  output  DWidth  read data to master
- resp_o  output  1  0 = OKAY, 1 = ERROR
- ready_o  output  1  data phase complete

## Operation
- An address phase is accepted when sel_i & ready_i & trans_i ∈ {NONSEQ, SEQ}. On acceptance, addr_i and write_i are registered. IDLE or BUSY transfers, or sel_i=0, lead to StIdle.
- A transfer is illegal if it misses the window or if addr_i[1:0] != 0. An illegal transfer goes to StErr1, and no NPU access is made.
- StIdle: ready_o=1, resp_o=0, cen_o=0.
- StWrite (1 cycle): cen_o=1, wen_o=1, addr_o=registered address, wdata_o=wdata_i; ready_o=1, resp_o=0.
- StRead: in the first cycle, cen_o=1, wen_o=0 and the latency counter is set to 0. The counter increments each cycle. While cnt < RdLatency, ready_o=0. When cnt == RdLatency, ready_o=1, rdata_o=rdata_i, and rdata_i is captured into the hold register.
- StErr1: resp_o=1, ready_o=0. StErr2: resp_o=1, ready_o=1. The slave always passes through StErr1 then StErr2.
- A new address phase is evaluated only in a cycle where ready_o=1 (end of the current data phase). Its decode selects the next state: StWrite, StRead, StErr1, or StIdle.
- When the slave is not completing a read, rdata_o = hold register (last read data).
- addr_o holds the registered address when cen_o=0.

## Timing
- Reset values: state StIdle, cen_o=0, wen_o=0, resp_o=0, ready_o=1, rdata_o=0, addr_o=0, counter=0, hold register=0.
- Reset is asynchronous, so asserting it mid-transfer aborts immediately. No further cen_o is issued and any pending read data is discarded.
- Write: 1 data-phase cycle, zero wait states.
- Read: RdLatency+1 data-phase cycles, i.e. RdLatency wait states.
- Error: exactly 2 cycles, regardless of RdLatency.
- Back-to-back transfers: write in data phase at T, read accepted at T, read cen_o at T+1. This causes no NPU port conflict. At most one cen_o is asserted per cycle.
- An address phase presented while ready_o=0 (read wait or StErr1) is ignored. The master must hold it until ready_o=1.
- After StErr2, a transfer accepted in the same cycle proceeds normally. The master is allowed to cancel with IDLE.

## Test plan
- Reset then write 0x1000_0010 ← 0xDEAD_BEEF, RdLatency=1. Required response: one cycle with cen_o=1, wen_o=1, addr_o=0x1000_0010, wdata_o=0xDEAD_BEEF, ready_o=1, resp_o=0.
- Read 0x1000_0010 with RdLatency=3 and NPU model returning 0xDEAD_BEEF. Required response: cen_o=1, wen_o=0 on data cycle 0; ready_o=0 for 3 cycles; rdata_o=0xDEAD_BEEF with ready_o=1 on cycle 3; rdata_o holds 0xDEAD_BEEF afterwards.
- Read 0x2000_0000 (out of window) and write 0x1000_0002 (misaligned). Required response for each: resp_o=1/ready_o=0, then resp_o=1/ready_o=1; cen_o never asserted.
- Back-to-back write A, read A, write B, with RdLatency=2. Required response: cen_o pulses in consecutive data phases, the read returns the A data, and total completion takes 1+3+1 cycles.
- Assert rst_ni low during cycle 1 of a RdLatency=4 read. Required response: all outputs go immediately to reset values, no further cen_o is issued, and the first transfer after reset completes normally.
- BUSY/IDLE transfers, sel_i=0 with NONSEQ, and ready_i=0 with NONSEQ. Required response: no state change and no cen_o; ready_o=1, resp_o=0.
